change_dispenser: RTL
=====================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter PULSE_CYCLES, default 4, number of cycles each coin-eject strobe is held high (legal 1..15).
REQ-002 Parameter ACK_TIMEOUT, default 1023, maximum cycles to wait for Ack after a strobe (legal 1..1023).
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Candy  input  1  vend level from the vending-machine stage; a 0->1 transition starts a change cycle.
REQ-006 Number  input  6  change owed in cents, valid in the cycle Candy rises.
REQ-007 Ack  input  1  coin mechanism level, high = last coin physically ejected.
REQ-008 CoinQ, CoinD, CoinN  output  1 each  eject strobes for quarter, dime and nickel.
REQ-009 Busy  output  1  high while a change cycle is in progress.
REQ-010 Done  output  1  one-cycle pulse when all change is paid.
REQ-011 Fault  output  1  sticky error flag.
REQ-012 Remaining  output  6  cents still owed.

Function
REQ-013 The block SHALL register Candy into Candy_d every cycle and define start = Candy & ~Candy_d.
REQ-014 States SHALL be IDLE, SELECT, PULSE, WAIT_ACK, DONE, FAULT.
REQ-015 In IDLE, on start with Number a multiple of 5 and <= 45, the block SHALL load Remaining = Number and enter SELECT.
REQ-016 In IDLE, on start with Number not a multiple of 5 or > 45, the block SHALL enter FAULT with Remaining = Number.
REQ-017 In SELECT, the block SHALL choose a coin greedily: Q if Remaining >= 25, else D if >= 10, else N if >= 5. It SHALL latch the choice, subtract its value from Remaining on the same edge, and enter PULSE.
REQ-018 In SELECT with Remaining == 0, the block SHALL enter DONE (Number = 0 therefore yields Done with no strobes).
REQ-019 In PULSE, only the latched coin strobe SHALL be high, for exactly PULSE_CYCLES consecutive cycles, after which the block SHALL enter WAIT_ACK.
REQ-020 Only one of CoinQ/CoinD/CoinN SHALL ever be high, and only in PULSE.
REQ-021 In WAIT_ACK, the block SHALL count cycles and, on Ack sampled high, enter SELECT.
REQ-022 If Ack remains low for ACK_TIMEOUT cycles in WAIT_ACK, the block SHALL enter FAULT.
REQ-023 Ack SHALL be ignored outside WAIT_ACK.
REQ-024 DONE SHALL last one cycle with Done=1, then the block SHALL return to IDLE.
REQ-025 Busy SHALL be 1 in SELECT, PULSE and WAIT_ACK, and 0 otherwise.
REQ-026 Start events outside IDLE (including in DONE) SHALL be ignored; Candy held high SHALL NOT retrigger.
REQ-027 FAULT SHALL hold Fault=1, all strobes 0, Busy=0, and Remaining frozen until Reset.
REQ-028 Remaining arithmetic SHALL be 6-bit unsigned and never underflow (guaranteed by REQ-017).
REQ-029 Coin sequences SHALL be: 5=N; 10=D; 15=D,N; 20=D,D; 25=Q; 30=Q,N; 35=Q,D; 40=Q,D,N; 45=Q,D,D.
REQ-030 Latency from the start edge to the first strobe SHALL be exactly 2 clock edges (IDLE->SELECT, SELECT->PULSE).

Reset
REQ-031 On Reset=1 at a clock edge, the block SHALL set state IDLE, Candy_d=0, Remaining=0, all counters 0, and all outputs 0, regardless of state, including mid-PULSE and FAULT.
REQ-032 A Candy already high when Reset deasserts SHALL start a cycle (Candy_d=0 after reset).

Verification
REQ-033 Candy 0->1, Number=40, Ack pulsed high 3 cycles after each strobe ends -> CoinQ, CoinD, CoinN, each high 4 cycles; Remaining 15, 5, 0; one Done pulse; Fault=0.
REQ-034 Candy 0->1, Number=0 -> no strobes, Done high exactly one cycle, 2 edges after start.
REQ-035 Candy 0->1, Number=17 -> Fault=1, Remaining=17, no strobes, Busy=0; cleared by Reset.
REQ-036 Number=25, Ack never asserted -> CoinQ for 4 cycles, then Fault=1 after 1023 WAIT_ACK cycles.
REQ-037 Number=30, Reset asserted during the first CoinQ strobe -> next cycle all outputs 0; a new Candy edge with Number=10 yields a single CoinD.
REQ-038 Candy held high through a full Number=15 cycle, plus a spurious Candy re-rise during WAIT_ACK -> exactly D,N dispensed and one Done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// Change dispenser: pays owed change greedily as quarter/dime/nickel eject strobes,
// handshaking each coin with the mechanism's Ack and faulting on bad input or timeout.
module change_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT  = 1023
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Candy,
  input  logic [5:0] Number,
  input  logic       Ack,
  output logic       CoinQ,
  output logic       CoinD,
  output logic       CoinN,
  output logic       Busy,
  output logic       Done,
  output logic       Fault,
  output logic [5:0] Remaining
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_ACK, DONE, FAULT} state_t;
  typedef enum logic [1:0] {COIN_NONE, COIN_Q, COIN_D, COIN_N} coin_t;

  localparam logic [3:0] PMAX = 4'(PULSE_CYCLES - 1);
  localparam logic [9:0] AMAX = 10'(ACK_TIMEOUT - 1);

  state_t     state, state_nx;
  coin_t      coin, coin_nx;
  logic       candy_d;
  logic       start;
  logic       number_ok;
  logic [5:0] rem_nx;
  logic [3:0] pcnt, pcnt_nx;
  logic [9:0] acnt, acnt_nx;

  assign start = Candy & ~candy_d;

  always_comb begin
    case (Number)
      6'd0, 6'd5, 6'd10, 6'd15, 6'd20,
      6'd25, 6'd30, 6'd35, 6'd40, 6'd45: number_ok = 1'b1;
      default:                           number_ok = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      coin      <= COIN_NONE;
      candy_d   <= 1'b0;
      Remaining <= '0;
      pcnt      <= '0;
      acnt      <= '0;
    end else begin
      state     <= state_nx;
      coin      <= coin_nx;
      candy_d   <= Candy;
      Remaining <= rem_nx;
      pcnt      <= pcnt_nx;
      acnt      <= acnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    coin_nx  = coin;
    rem_nx   = Remaining;
    pcnt_nx  = pcnt;
    acnt_nx  = acnt;
    case (state)
      IDLE: begin
        if (start) begin
          rem_nx   = Number;
          state_nx = number_ok ? SELECT : FAULT;
        end
      end
      SELECT: begin
        pcnt_nx = '0;
        // Coin choice and the subtraction share one edge, so Remaining already
        // reflects the coin being ejected during its strobe.
        if (Remaining >= 6'd25) begin
          coin_nx  = COIN_Q;
          rem_nx   = Remaining - 6'd25;
          state_nx = PULSE;
        end else if (Remaining >= 6'd10) begin
          coin_nx  = COIN_D;
          rem_nx   = Remaining - 6'd10;
          state_nx = PULSE;
        end else if (Remaining >= 6'd5) begin
          coin_nx  = COIN_N;
          rem_nx   = Remaining - 6'd5;
          state_nx = PULSE;
        end else begin
          coin_nx  = COIN_NONE;
          state_nx = DONE;
        end
      end
      PULSE: begin
        if (pcnt == PMAX) begin
          acnt_nx  = '0;
          state_nx = WAIT_ACK;
        end else begin
          pcnt_nx = pcnt + 4'd1;
        end
      end
      WAIT_ACK: begin
        if (Ack) begin
          state_nx = SELECT;
        end else if (acnt == AMAX) begin
          state_nx = FAULT;
        end else begin
          acnt_nx = acnt + 10'd1;
        end
      end
      DONE:    state_nx = IDLE;
      FAULT:   state_nx = FAULT;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    CoinQ = (state == PULSE) && (coin == COIN_Q);
    CoinD = (state == PULSE) && (coin == COIN_D);
    CoinN = (state == PULSE) && (coin == COIN_N);
    Busy  = (state == SELECT) || (state == PULSE) || (state == WAIT_ACK);
    Done  = (state == DONE);
    Fault = (state == FAULT);
  end

endmodule
